// File: rtl/distribution_unit_multi.sv
// Multi-channel distribution-load unit: stalls the core, streams NUM_BINS bin words for one
// channel over valid/ready and presents them packed. Optional one-entry cache: DU_CACHE_EN.
module distribution_unit_multi #(
    parameter int unsigned NUM_BINS     = 16,
    parameter int unsigned BIN_WIDTH    = 16,
    parameter int unsigned NUM_CHANNELS = 4,
    localparam int unsigned CH_BITS     = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          DUCtrl,
    input  logic [31:0]                   rs1,
    output logic [NUM_BINS*BIN_WIDTH-1:0] DU_result,
    output logic                          du_clk_stall,
    output logic                          du_done,
    output logic                          du_error,
    output logic                          src_req,
    output logic [CH_BITS-1:0]            src_channel,
    output logic                          src_ready,
    input  logic                          src_valid,
    input  logic [BIN_WIDTH-1:0]          src_data
);

    localparam int unsigned CNT_W = $clog2(NUM_BINS) + 1;
    localparam int unsigned RES_W = NUM_BINS * BIN_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_FETCH    = 2'd1,
        S_DATA_OUT = 2'd2,
        S_DONE     = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RES_W-1:0]   buf_q, buf_d;
    logic [RES_W-1:0]   result_q, result_d;
    logic               err_q, err_d;
    logic               stall_q, stall_d;
    logic               done_q, done_d;
    logic               error_q, error_d;
    logic               req_q, req_d;
    logic               rdy_q, rdy_d;
    logic [CH_BITS-1:0] ch_q, ch_d;

    logic in_range_c;
    logic hit_c;
    logic accept_c;
    logic last_c;

    assign in_range_c = (rs1 < 32'(NUM_CHANNELS));
    assign accept_c   = (state_q == S_FETCH) && rdy_q && src_valid;
    assign last_c     = (cnt_q == CNT_W'(NUM_BINS - 1));

`ifdef DU_CACHE_EN
    // One-entry cache of the last fully fetched channel; the buffer itself is the data store.
    logic [CH_BITS-1:0] tag_q, tag_d;
    logic               tag_vld_q, tag_vld_d;

    assign hit_c = tag_vld_q && (tag_q == rs1[CH_BITS-1:0]);

    always_comb begin
        tag_d     = tag_q;
        tag_vld_d = tag_vld_q;
        if ((state_q == S_IDLE) && DUCtrl && !in_range_c) begin
            tag_vld_d = 1'b0;
        end
        if (accept_c && last_c) begin
            tag_d     = ch_q;
            tag_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tag_q     <= '0;
            tag_vld_q <= 1'b0;
        end else begin
            tag_q     <= tag_d;
            tag_vld_q <= tag_vld_d;
        end
    end
`else
    assign hit_c = 1'b0;
`endif

    // Next-state and registered-output logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        buf_d    = buf_q;
        result_d = result_q;
        err_d    = err_q;
        stall_d  = stall_q;
        done_d   = 1'b0;
        error_d  = 1'b0;
        req_d    = req_q;
        rdy_d    = rdy_q;
        ch_d     = ch_q;

        case (state_q)
            S_IDLE: begin
                if (DUCtrl) begin
                    stall_d = 1'b1;
                    cnt_d   = '0;
                    if (!in_range_c) begin
                        err_d   = 1'b1;
                        state_d = S_DATA_OUT;
                    end else if (hit_c) begin
                        err_d   = 1'b0;
                        state_d = S_DATA_OUT;
                    end else begin
                        err_d   = 1'b0;
                        ch_d    = rs1[CH_BITS-1:0];
                        req_d   = 1'b1;
                        rdy_d   = 1'b1;
                        state_d = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                if (accept_c) begin
                    for (int k = 0; k < int'(NUM_BINS); k++) begin
                        if (cnt_q == CNT_W'(k)) begin
                            buf_d[k*BIN_WIDTH +: BIN_WIDTH] = src_data;
                        end
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                    if (last_c) begin
                        req_d   = 1'b0;
                        rdy_d   = 1'b0;
                        state_d = S_DATA_OUT;
                    end
                end
            end
            S_DATA_OUT: begin
                result_d = err_q ? '0 : buf_q;
                done_d   = 1'b1;
                error_d  = err_q;
                stall_d  = 1'b0;
                state_d  = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            buf_q    <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
            stall_q  <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            req_q    <= 1'b0;
            rdy_q    <= 1'b0;
            ch_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            buf_q    <= buf_d;
            result_q <= result_d;
            err_q    <= err_d;
            stall_q  <= stall_d;
            done_q   <= done_d;
            error_q  <= error_d;
            req_q    <= req_d;
            rdy_q    <= rdy_d;
            ch_q     <= ch_d;
        end
    end

    assign DU_result    = result_q;
    assign du_clk_stall = stall_q;
    assign du_done      = done_q;
    assign du_error     = error_q;
    assign src_req      = req_q;
    assign src_ready    = rdy_q;
    assign src_channel  = ch_q;

endmodule

// File: tb/tb_distribution_unit_multi.sv
// Self-checking bench for distribution_unit_multi: directed requests, a behavioural
// expectation model (including the optional one-entry cache) and a result scoreboard.
module tb_distribution_unit_multi;

    localparam int unsigned NB  = 16;
    localparam int unsigned BW  = 16;
    localparam int unsigned NC  = 4;
    localparam int unsigned CHB = 2;
    localparam int unsigned RW  = NB * BW;
`ifdef DU_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           reset_n;
    logic           DUCtrl;
    logic [31:0]    rs1;
    logic [RW-1:0]  DU_result;
    logic           du_clk_stall;
    logic           du_done;
    logic           du_error;
    logic           src_req;
    logic [CHB-1:0] src_channel;
    logic           src_ready;
    logic           src_valid;
    logic [BW-1:0]  src_data;

    distribution_unit_multi #(
        .NUM_BINS     (NB),
        .BIN_WIDTH    (BW),
        .NUM_CHANNELS (NC)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .DUCtrl       (DUCtrl),
        .rs1          (rs1),
        .DU_result    (DU_result),
        .du_clk_stall (du_clk_stall),
        .du_done      (du_done),
        .du_error     (du_error),
        .src_req      (src_req),
        .src_channel  (src_channel),
        .src_ready    (src_ready),
        .src_valid    (src_valid),
        .src_data     (src_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [RW-1:0] res;
        logic          err;
        int            lat;
        logic          fetch;
        logic [CHB-1:0] ch;
    } exp_t;

    exp_t           sb[$];
    int             errors = 0;
    int             checks = 0;
    logic [RW-1:0]  last_m;
    logic [CHB-1:0] tag_m;
    logic           vld_m;
    logic           hold;

    task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected outcome of one request, from the behavioural model.
    task automatic plan(input logic [31:0] ch, input int base, input int gap_len);
        exp_t e;
        e.ch = ch[CHB-1:0];
        if (ch >= 32'(NC)) begin
            e.res = '0; e.err = 1'b1; e.lat = 2; e.fetch = 1'b0;
            vld_m = 1'b0;
        end else if (CACHE && vld_m && (tag_m == ch[CHB-1:0])) begin
            e.res = last_m; e.err = 1'b0; e.lat = 2; e.fetch = 1'b0;
        end else begin
            for (int k = 0; k < int'(NB); k++) e.res[k*BW +: BW] = BW'(base + k);
            e.err = 1'b0; e.lat = int'(NB) + 2 + gap_len; e.fetch = 1'b1;
            last_m = e.res; tag_m = ch[CHB-1:0]; vld_m = 1'b1;
        end
        sb.push_back(e);
    endtask

    // Source model: one iteration per clock, outputs observed on the falling edge.
    task automatic feed(input int base, input int gap_after, input int gap_len, input int abort_at,
                        output int n, output int stall_bad, output bit saw_req);
        int words;
        int gaps;
        bit done_seen;
        words = 0; gaps = 0; done_seen = 1'b0;
        n = 0; stall_bad = 0; saw_req = 1'b0;
        while (!done_seen && n < 200) begin
            if (src_req && src_ready && words < int'(NB)) begin
                if (words == gap_after && gaps < gap_len) begin
                    src_valid = 1'b0;
                    gaps++;
                end else begin
                    src_valid = 1'b1;
                    src_data  = BW'(base + words);
                    words++;
                end
            end else begin
                src_valid = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
            n++;
            if (!hold) DUCtrl = 1'b0;
            if (src_req) saw_req = 1'b1;
            if (abort_at >= 0 && words == abort_at) begin
                src_valid = 1'b0;
                return;
            end
            if (du_done) done_seen = 1'b1;
            else if (!du_clk_stall) stall_bad++;
        end
        src_valid = 1'b0;
        chk("done_timeout", RW'(done_seen), RW'(1));
    endtask

    task automatic finish_check(input string tag, input int n, input int lat_adj,
                                input int stall_bad, input bit saw_req);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, RW'(0), RW'(1));
            return;
        end
        e = sb.pop_front();
        chk({tag, "_latency"}, RW'(n + lat_adj), RW'(e.lat));
        chk({tag, "_result"}, DU_result, e.res);
        chk({tag, "_error"}, RW'(du_error), RW'(e.err));
        chk({tag, "_src_req_seen"}, RW'(saw_req), RW'(e.fetch));
        chk({tag, "_stall_held"}, RW'(stall_bad), RW'(0));
        chk({tag, "_stall_low_at_done"}, RW'(du_clk_stall), RW'(0));
        if (e.fetch) chk({tag, "_channel"}, RW'(src_channel), RW'(e.ch));
        @(negedge clk);
        chk({tag, "_done_pulse"}, RW'({du_done, du_error}), RW'(0));
    endtask

    task automatic request(input string tag, input logic [31:0] ch, input int base,
                           input int gap_after, input int gap_len);
        int  n;
        int  sbad;
        bit  saw;
        plan(ch, base, gap_len);
        DUCtrl = 1'b1;
        rs1    = ch;
        feed(base, gap_after, gap_len, -1, n, sbad, saw);
        finish_check(tag, n, 0, sbad, saw);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_result"}, DU_result, '0);
        chk({tag, "_ctl"}, RW'({du_clk_stall, du_done, du_error, src_req, src_ready}), RW'(0));
        chk({tag, "_channel"}, RW'(src_channel), RW'(0));
    endtask

    initial begin
        int n;
        int sbad;
        bit saw;

        reset_n = 1'b0; DUCtrl = 1'b0; rs1 = '0; src_valid = 1'b0; src_data = '0;
        hold = 1'b0; vld_m = 1'b0; last_m = '0; tag_m = '0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        reset_n = 1'b1;
        @(negedge clk);

        // Normal fetch, words 1..16 on channel 2.
        request("ch2", 32'd2, 1, -1, 0);
        // Out-of-range channels; also drop any cached channel.
        request("rs1_4", 32'h0000_0004, 0, -1, 0);
        request("rs1_max", 32'hFFFF_FFFF, 0, -1, 0);
        // Three idle source cycles after bin 5 stretch the fetch.
        request("ch2_gap", 32'd2, 1, 6, 3);

        // DUCtrl held through completion must not be re-taken in DONE.
        hold = 1'b1;
        plan(32'd0, 16'h0400, 0);
        DUCtrl = 1'b1; rs1 = 32'd0;
        feed(16'h0400, -1, 0, -1, n, sbad, saw);
        finish_check("hold_first", n, 0, sbad, saw);
        chk("hold_not_retaken", RW'({du_clk_stall, src_req}), RW'(0));
        plan(32'd0, 16'h0500, 0);
        @(negedge clk);
        chk("hold_second_start", RW'(du_clk_stall), RW'(1));
        hold = 1'b0; DUCtrl = 1'b0;
        feed(16'h0500, -1, 0, -1, n, sbad, saw);
        finish_check("hold_second", n, 1, sbad, saw);

        // Reset during bin 7 aborts everything at once.
        DUCtrl = 1'b1; rs1 = 32'd2;
        feed(16'h0800, -1, 0, 7, n, sbad, saw);
        reset_n = 1'b0;
        vld_m = 1'b0;
        #1;
        chk_all_zero("abort");
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        request("post_reset_ch1", 32'd1, 16'h0900, -1, 0);

        // Repeated channel: cache hit when built with the cache, refetch otherwise.
        request("ch3_a", 32'd3, 16'h0300, -1, 0);
        request("ch3_b", 32'd3, 16'h0600, -1, 0);
        request("rs1_9", 32'd9, 0, -1, 0);
        request("ch3_c", 32'd3, 16'h0700, -1, 0);

        chk("scoreboard_drained", RW'(sb.size()), RW'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
